noc_port_arbiter: RTL and testbench
===================================

# noc_port_arbiter

Clocked three-way arbiter that shares one output link of a NoC tree node between three packet sources: parent (input 0), child 0 (input 1) and child 1 (input 2). It sits in front of each node output port, downstream of the per-input route decision, and serialises the 47-bit packets (bit 46 ifm/filter select, [45:43] destination, [42:40] source, [39:0] data) onto the link through a small output FIFO. Packets pass through unmodified; the arbiter never inspects the address fields.

## Interface
- WIDTH, 47, packet width in bits
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  3  per-input packet valid, bit i = input i
- in_data  in  3*WIDTH  input i packet at [i*WIDTH +: WIDTH]
- in_ready  out  3  one-hot grant/accept; at most one bit set
- out_valid  out  1  FIFO head valid
- out_data  out  WIDTH  FIFO head packet
- out_src  out  2  input index (0..2) of the head packet
- out_ready  in  1  downstream accept
- pkt_count  out  16  packets accepted since reset, wraps

## Operation
- State: FIFO storage (DEPTH × (WIDTH+2)), write/read pointers, occupancy `count` (0..DEPTH), round-robin pointer `rr` (0..2), `pkt_count`.
- Space: `space = (count < DEPTH)`, computed from registered `count` only; a same-cycle pop never creates space for a push.
- Grant (combinational): when `space`, search inputs in order rr, rr+1, rr+2 (mod 3); the first with in_valid set is granted and drives in_ready. No valid input or no space → in_ready = 3'b000. in_ready depends on in_valid combinationally.
- Push: granted input i with in_valid[i] & in_ready[i] at a rising edge writes {i, in_data[i]} into the FIFO, sets rr ← (i+1) mod 3, increments pkt_count (0xFFFF → 0x0000).
- rr is unchanged in cycles with no push.
- Pop: out_valid & out_ready at a rising edge advances the read pointer.
- Simultaneous push and pop: both occur; count unchanged.
- out_valid = (count ≠ 0); out_data/out_src = FIFO head. Holds stable while out_valid & !out_ready.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH or goes below 0.
- Reset at any time: FIFO contents discarded, count = 0, rr = 0, pkt_count = 0. In-flight transfers are lost, not replayed.

## Timing
- Reset values: out_valid = 0, out_src = 0, out_data = 0, pkt_count = 0. in_ready = 0 while reset is asserted.
- Latency: a packet accepted at edge k into an empty FIFO appears on out_valid/out_data immediately after edge k.
- Throughput: 1 packet/cycle with out_ready held high. No bubbles between back-to-back grants.
- Handshake: both sides are valid/ready. The source holds in_valid/in_data until accepted. in_valid must not depend on in_ready.
- Full: with count = DEPTH, in_ready = 0 for the whole cycle, even if out_ready = 1.
- Fairness: any continuously valid input is granted within 3 accepting cycles.

## Configuration
- PARENT_PRIORITY_EN defined: input 0 wins whenever in_valid[0] and space are set. Inputs 1 and 2 round-robin between themselves only when input 0 is idle. rr updates only on child grants and holds values 1 or 2 only (reset value 1). Parent starvation of the children is permitted.
- Not defined: fair three-way round-robin as described above (rr resets to 0).

## Test plan
- Reset: assert reset mid-cycle with any inputs → out_valid = 0, in_ready = 3'b000, pkt_count = 0, with no clock edge required.
- Single packet: in_valid = 3'b001, in_data[46:0] = 47'h5C_FFFF_FFFF_FF → in_ready = 3'b001; next cycle out_valid = 1, out_data = 47'h5C_FFFF_FFFF_FF, out_src = 0, pkt_count = 1.
- Fair arbitration (macro off): all three valid with distinct data, out_ready = 1 → out_src sequence 0,1,2,0,1,2, one packet per cycle.
- Backpressure: out_ready = 0, all inputs valid → exactly 2 accepts (src 0, 1), then in_ready = 0 and count = 2. Raise out_ready → packets drain in order 0,1, then input 2 is granted.
- Reset mid-operation: FIFO holds 2 packets, pulse reset → out_valid = 0. First post-reset grant with all inputs valid goes to input 0.
- Macro on: all valid → out_src 0,0,0. Deassert input 0 → sequence 1,2,1,2. Reassert input 0 → 0 on the next accepting cycle.

Source files
------------

// File: rtl/noc_port_arbiter.sv
// Three-way NoC output-port arbiter feeding a small output FIFO.
// Define PARENT_PRIORITY_EN to give input 0 strict priority over the children.
module noc_port_arbiter #(
  parameter int WIDTH = 47,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         in_valid,
  input  logic [3*WIDTH-1:0] in_data,
  output logic [2:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_src,
  input  logic               out_ready,
  output logic [15:0]        pkt_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef logic [WIDTH+1:0] entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    rr;
  logic          space;
  logic          gnt_vld;
  logic [1:0]    gnt_idx;
  logic          push;
  logic          pop;

  // a pop in the same cycle never frees a slot for a push
  assign space = count < FULL;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
`ifdef PARENT_PRIORITY_EN
    unique case (1'b1)
      in_valid[0]: begin
        gnt_vld = 1'b1;
        gnt_idx = 2'd0;
      end
      (rr == 2'd1) && in_valid[1],
      (rr == 2'd2) && in_valid[1] && !in_valid[2]: begin
        gnt_vld = 1'b1;
        gnt_idx = 2'd1;
      end
      in_valid[2]: begin
        gnt_vld = 1'b1;
        gnt_idx = 2'd2;
      end
      default: ;
    endcase
`else
    unique case (rr)
      2'd1: begin
        gnt_vld = |in_valid;
        gnt_idx = in_valid[1] ? 2'd1 :
                  in_valid[2] ? 2'd2 : 2'd0;
      end
      2'd2: begin
        gnt_vld = |in_valid;
        gnt_idx = in_valid[2] ? 2'd2 :
                  in_valid[0] ? 2'd0 : 2'd1;
      end
      default: begin
        gnt_vld = |in_valid;
        gnt_idx = in_valid[0] ? 2'd0 :
                  in_valid[1] ? 2'd1 : 2'd2;
      end
    endcase
`endif
  end

  assign in_ready  = (gnt_vld && space && !reset)
                   ? 3'(3'b001 << gnt_idx) : 3'b000;
  assign push      = |(in_valid & in_ready);
  assign out_valid = count != '0;
  assign pop       = out_valid & out_ready;
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[WIDTH-1:0] : '0;
  assign out_src   = out_valid ? head[WIDTH+1:WIDTH] : 2'd0;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {gnt_idx, in_data[gnt_idx*WIDTH +: WIDTH]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
`ifdef PARENT_PRIORITY_EN
      rr        <= 2'd1;
`else
      rr        <= 2'd0;
`endif
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        pkt_count <= pkt_count + 16'd1;
`ifdef PARENT_PRIORITY_EN
        if (gnt_idx != 2'd0)
          rr <= (gnt_idx == 2'd1) ? 2'd2 : 2'd1;
`else
        rr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
`endif
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed vector bench for noc_port_arbiter.
// Covers reset, fairness, backpressure, full, mid-run reset and counter wrap.
module tb_noc_port_arbiter;

  localparam int W = 47;
  localparam logic [W-1:0] D0 = 47'h5C_FFFF_FFFF_FF;
  localparam logic [W-1:0] D1 = 47'h12_3456_789A_BC;
  localparam logic [W-1:0] D2 = 47'h7A_BCDE_F012_34;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   in_valid = 3'b000;
  logic [3*W-1:0] in_data;
  logic [2:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_ready = 1'b0;
  logic [15:0]  pkt_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    logic [2:0]  iv;
    logic        ordy;
    logic [2:0]  rdy;
    logic        ov;
    logic [1:0]  src;
    logic [15:0] pkt;
  } vec_t;

  vec_t tv[$];

  assign in_data = {D2, D1, D0};

  always #5 clk = ~clk;

  noc_port_arbiter #(.WIDTH(W), .DEPTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_src(out_src),
    .out_ready(out_ready),
    .pkt_count(pkt_count)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] dat(input logic [1:0] s);
    return (s == 2'd0) ? D0 : (s == 2'd1) ? D1 : D2;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_src", 64'(out_src), 64'h0);
    chk("rst_pkt", 64'(pkt_count), 64'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    if (v.rst) do_reset();
    in_valid  = v.iv;
    out_ready = v.ordy;
    #1;
    chk($sformatf("v%0d_in_ready", n), 64'(in_ready), 64'(v.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_out_valid", n), 64'(out_valid), 64'(v.ov));
    if (v.ov) begin
      chk($sformatf("v%0d_out_src", n), 64'(out_src), 64'(v.src));
      chk($sformatf("v%0d_out_data", n), 64'(out_data), 64'(dat(v.src)));
    end
    chk($sformatf("v%0d_pkt", n), 64'(pkt_count), 64'(v.pkt));
  endtask

  initial begin
`ifdef PARENT_PRIORITY_EN
    tv.push_back('{1, 3'b001, 1, 3'b001, 1, 2'd0, 16'd1});
    tv.push_back('{0, 3'b000, 1, 3'b000, 0, 2'd0, 16'd1});
    tv.push_back('{1, 3'b111, 1, 3'b001, 1, 2'd0, 16'd1});
    tv.push_back('{0, 3'b111, 1, 3'b001, 1, 2'd0, 16'd2});
    tv.push_back('{0, 3'b111, 1, 3'b001, 1, 2'd0, 16'd3});
    tv.push_back('{0, 3'b110, 1, 3'b010, 1, 2'd1, 16'd4});
    tv.push_back('{0, 3'b110, 1, 3'b100, 1, 2'd2, 16'd5});
    tv.push_back('{0, 3'b110, 1, 3'b010, 1, 2'd1, 16'd6});
    tv.push_back('{0, 3'b110, 1, 3'b100, 1, 2'd2, 16'd7});
    tv.push_back('{0, 3'b111, 1, 3'b001, 1, 2'd0, 16'd8});
    tv.push_back('{0, 3'b000, 1, 3'b000, 0, 2'd0, 16'd8});
`else
    tv.push_back('{1, 3'b001, 1, 3'b001, 1, 2'd0, 16'd1});
    tv.push_back('{0, 3'b000, 1, 3'b000, 0, 2'd0, 16'd1});
    tv.push_back('{1, 3'b111, 1, 3'b001, 1, 2'd0, 16'd1});
    tv.push_back('{0, 3'b111, 1, 3'b010, 1, 2'd1, 16'd2});
    tv.push_back('{0, 3'b111, 1, 3'b100, 1, 2'd2, 16'd3});
    tv.push_back('{0, 3'b111, 1, 3'b001, 1, 2'd0, 16'd4});
    tv.push_back('{0, 3'b111, 1, 3'b010, 1, 2'd1, 16'd5});
    tv.push_back('{0, 3'b111, 1, 3'b100, 1, 2'd2, 16'd6});
    tv.push_back('{0, 3'b000, 1, 3'b000, 0, 2'd0, 16'd6});
    tv.push_back('{0, 3'b111, 0, 3'b001, 1, 2'd0, 16'd7});
    tv.push_back('{0, 3'b111, 0, 3'b010, 1, 2'd0, 16'd8});
    tv.push_back('{0, 3'b111, 0, 3'b000, 1, 2'd0, 16'd8});
    tv.push_back('{0, 3'b111, 1, 3'b000, 1, 2'd1, 16'd8});
    tv.push_back('{0, 3'b111, 1, 3'b100, 1, 2'd2, 16'd9});
    tv.push_back('{0, 3'b000, 1, 3'b000, 0, 2'd0, 16'd9});
    tv.push_back('{0, 3'b010, 1, 3'b010, 1, 2'd1, 16'd10});
    tv.push_back('{0, 3'b101, 1, 3'b100, 1, 2'd2, 16'd11});
`endif

    #2;
    do_reset();
    foreach (tv[i]) run_vec(i, tv[i]);

    // fill the FIFO, then reset mid-cycle with every input still valid
    in_valid  = 3'b111;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("fill_out_valid", 64'(out_valid), 64'h1);
    chk("fill_in_ready", 64'(in_ready), 64'h0);
    #2;
    do_reset();
    run_vec(100, '{0, 3'b111, 1, 3'b001, 1, 2'd0, 16'd1});

    // hold the head under backpressure and confirm it stays put
    in_valid  = 3'b000;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_src", 64'(out_src), 64'h0);
    chk("hold_data", 64'(out_data), 64'(D0));
    @(posedge clk);
    #1;
    chk("hold_src2", 64'(out_src), 64'h0);
    chk("hold_pkt", 64'(pkt_count), 64'h1);

    // 65536 accepts wrap the counter back to zero
    do_reset();
    in_valid  = 3'b001;
    out_ready = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    chk("wrap_pkt", 64'(pkt_count), 64'h0);
    chk("wrap_out_valid", 64'(out_valid), 64'h1);
    in_valid = 3'b000;
    @(posedge clk);
    #1;
    chk("wrap_drain", 64'(out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
